oam_dma_ctrl: RTL and testbench
===============================

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, the CPU address whose write starts a DMA.
REQ-002 SHALL have port clk, input, 1, the single clock; each rising edge is one CPU cycle.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port cpu_addr, input, 16, the CPU bus address.
REQ-005 SHALL have port cpu_data_in, input, 8, the CPU write data; carries the source page number.
REQ-006 SHALL have port cpu_WE, input, 1, the CPU write strobe.
REQ-007 SHALL have port oam_addr_base, input, 8, the current OAMADDR value from the register interface.
REQ-008 SHALL have port cpu_halt, output, 1; high stalls the CPU.
REQ-009 SHALL have port dma_busy, output, 1; high while a transfer is in progress.
REQ-010 SHALL have port dma_addr, output, 16, the source read address.
REQ-011 SHALL have port dma_rd, output, 1, the source read strobe.
REQ-012 SHALL have port dma_data_in, input, 8; read data arrives one clk after dma_rd.
REQ-013 SHALL have port oam_addr_out, output, 8, the OAM write address.
REQ-014 SHALL have port oam_data_out, output, 8, the OAM write data.
REQ-015 SHALL have port oam_WE, output, 1, the OAM write enable; single-cycle pulse per byte.

Function
REQ-016 SHALL detect a trigger when cpu_WE=1 and cpu_addr==DMA_REG_ADDR are sampled at a clk edge in state IDLE, and SHALL latch page<=cpu_data_in and base<=oam_addr_base at that edge.
REQ-017 SHALL keep a parity flop that resets to 0 and toggles every clk.
REQ-018 SHALL implement states IDLE, HALT, ALIGN, READ and WRITE, with registered state and outputs decoded from state (Moore).
REQ-019 SHALL take these transitions:
- IDLE->HALT on trigger.
- HALT->READ if parity==1 during HALT; otherwise HALT->ALIGN.
- ALIGN->READ.
- READ->WRITE.
- WRITE->READ if idx!=8'hFF; otherwise WRITE->IDLE.
REQ-020 SHALL therefore start every READ on a parity-0 cycle; a transfer occupies 513 cycles (HALT,READ...) or 514 cycles (HALT,ALIGN,READ...).
REQ-021 SHALL hold an 8-bit idx that clears on trigger and increments only on leaving WRITE, wrapping FF->00.
REQ-022 SHALL in READ drive dma_rd=1 and dma_addr={page,idx}; in all other states dma_rd=0 and dma_addr=16'h0000.
REQ-023 SHALL in WRITE drive oam_WE=1, oam_data_out=dma_data_in and oam_addr_out=base+idx (mod 256); in all other states oam_WE=0.
REQ-024 SHALL drive cpu_halt=dma_busy=1 in every state except IDLE.
REQ-025 SHALL ignore writes to DMA_REG_ADDR while not IDLE; neither page nor base change.
REQ-026 SHALL allow a new trigger on the first IDLE cycle after a completed transfer.
REQ-027 SHALL use page 8'hFF normally, with dma_addr spanning FF00..FFFF and no carry into the page.

Reset
REQ-028 SHALL on reset assert, at any time including mid-transfer, immediately force state=IDLE, idx=0, parity=0, page=0, base=0, cpu_halt=0, dma_busy=0, dma_rd=0, dma_addr=0, oam_WE=0, oam_addr_out=0 and oam_data_out=0; a partial transfer is abandoned and not resumed.

Verification
REQ-029 SHALL be tested with: trigger page 8'h02 and base 8'h00 in a parity-1 HALT -> 513 busy cycles, OAM[n]=mem[16'h0200+n] for n=0..255, and cpu_halt low on the cycle after the last oam_WE.
REQ-030 SHALL be tested with: the same transfer triggered so HALT falls on parity 0 -> one ALIGN cycle, 514 busy cycles, and every dma_rd on parity 0.
REQ-031 SHALL be tested with: base 8'hF8 -> the first write goes to OAM 8'hF8 and byte 8 goes to OAM 8'h00 (wrap).
REQ-032 SHALL be tested with: a second write of 8'h05 to 16'h4014 during a transfer -> ignored, and all source addresses remain in the original page.
REQ-033 SHALL be tested with: reset asserted after 100 OAM writes -> all outputs 0 asynchronously, and no further oam_WE after reset releases.
REQ-034 SHALL be tested with: back-to-back triggers on the first IDLE cycle -> the second transfer starts with no lost cycle.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG_ADDR halts the CPU and copies
// 256 bytes from page {page,00..FF} into OAM starting at the latched OAMADDR.
// Every source read lands on a parity-0 cycle; the byte is written to OAM on
// the following parity-1 cycle.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_WE,
  input  logic [7:0]  oam_addr_base,
  output logic        cpu_halt,
  output logic        dma_busy,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_data_in,
  output logic [7:0]  oam_addr_out,
  output logic [7:0]  oam_data_out,
  output logic        oam_WE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_parity;
  logic [7:0]  r_idx;
  logic [7:0]  r_page;
  logic [7:0]  r_base;
  logic        w_trigger;

  // A DMA request is only honoured while idle; later writes are ignored.
  assign w_trigger = (r_state == S_IDLE) && cpu_WE && (cpu_addr == DMA_REG_ADDR);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; HALT skips ALIGN when the following cycle is already parity 0.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_HALT: begin
        if (r_parity) begin
          w_next_state = S_READ;
        end else begin
          w_next_state = S_ALIGN;
        end
      end
      S_ALIGN: w_next_state = S_READ;
      S_READ:  w_next_state = S_WRITE;
      S_WRITE: begin
        if (r_idx != 8'hFF) begin
          w_next_state = S_READ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Cycle parity, byte index and the page/base captured at the trigger edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
      r_idx    <= 8'h00;
      r_page   <= 8'h00;
      r_base   <= 8'h00;
    end else begin
      r_parity <= ~r_parity;
      if (w_trigger) begin
        r_page <= cpu_data_in;
        r_base <= oam_addr_base;
        r_idx  <= 8'h00;
      end else if (r_state == S_WRITE) begin
        r_idx <= r_idx + 8'd1;
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  // Output decode from the registered state; everything is zero while idle.
  always_comb begin
    cpu_halt     = 1'b0;
    dma_busy     = 1'b0;
    dma_rd       = 1'b0;
    dma_addr     = 16'h0000;
    oam_WE       = 1'b0;
    oam_addr_out = 8'h00;
    oam_data_out = 8'h00;
    case (r_state)
      S_IDLE: begin
        cpu_halt = 1'b0;
        dma_busy = 1'b0;
      end
      S_HALT, S_ALIGN: begin
        cpu_halt = 1'b1;
        dma_busy = 1'b1;
      end
      S_READ: begin
        cpu_halt = 1'b1;
        dma_busy = 1'b1;
        dma_rd   = 1'b1;
        dma_addr = {r_page, r_idx};
      end
      S_WRITE: begin
        cpu_halt     = 1'b1;
        dma_busy     = 1'b1;
        oam_WE       = 1'b1;
        oam_addr_out = r_base + r_idx;
        oam_data_out = dma_data_in;
      end
      default: begin
        cpu_halt = 1'b0;
        dma_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized self-checking bench for oam_dma_ctrl. A source memory model
// answers dma_rd one cycle later; captured OAM writes are compared with
// OAM[(base+n)%256] = mem[page*256+n].
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_WE;
  logic [7:0]  oam_addr_base;
  logic        cpu_halt;
  logic        dma_busy;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  dma_data_in;
  logic [7:0]  oam_addr_out;
  logic [7:0]  oam_data_out;
  logic        oam_WE;

  int total = 0;
  int bad = 0;
  int cyc;

  logic [7:0] mem [0:65535];
  logic [7:0] tb_oam [0:255];

  // results of the most recent run_xfer / trigger
  int         x_busy, x_wrs, x_par_bad, x_page_bad, x_halt_ne, x_first_rd, x_hp;
  logic       x_halt_after, x_to, x_k1_busy;
  logic [7:0] x_first_addr, x_ninth_addr;

  always #5 clk = ~clk;

  oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_WE(cpu_WE), .oam_addr_base(oam_addr_base), .cpu_halt(cpu_halt),
    .dma_busy(dma_busy), .dma_addr(dma_addr), .dma_rd(dma_rd),
    .dma_data_in(dma_data_in), .oam_addr_out(oam_addr_out),
    .oam_data_out(oam_data_out), .oam_WE(oam_WE)
  );

  // Cycle counter: its LSB equals the parity of the current cycle since reset.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Source memory: data for a read shows up one clock after dma_rd, garbage otherwise.
  always @(posedge clk) begin
    if (dma_rd) dma_data_in <= mem[dma_addr];
    else        dma_data_in <= 8'($urandom);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int oam_errs(input logic [7:0] page, input logic [7:0] base);
    int n_err = 0;
    for (int n = 0; n < 256; n++) begin
      logic [7:0] a;
      logic [7:0] lo;
      lo = 8'(n);
      a  = base + lo;
      if (tb_oam[a] !== mem[{page, lo}]) n_err++;
    end
    return n_err;
  endfunction

  // Present a DMA register write; halt_par>=0 first waits so HALT lands on that parity.
  task automatic trigger(input logic [7:0] page, input logic [7:0] base, input int halt_par);
    if (halt_par >= 0) begin
      if (((cyc + 1) % 2) != halt_par) step();
    end
    for (int i = 0; i < 256; i++) tb_oam[i] = 8'hxx;
    x_hp          = (cyc + 1) % 2;
    cpu_addr      = 16'h4014;
    cpu_data_in   = page;
    oam_addr_base = base;
    cpu_WE        = 1'b1;
  endtask

  // Clock a transfer, sampling every cycle; returns on the first idle cycle or after stop_wr writes.
  task automatic run_xfer(input int inject_at, input int stop_wr, input logic [7:0] exp_page);
    logic prev_last;
    x_busy = 0; x_wrs = 0; x_par_bad = 0; x_page_bad = 0; x_halt_ne = 0;
    x_first_rd = -1; x_halt_after = 1'b1; x_to = 1'b1; x_k1_busy = 1'b0;
    x_first_addr = 8'h00; x_ninth_addr = 8'h00; prev_last = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      step();
      cpu_WE = (k == inject_at);
      if (k == inject_at) begin
        cpu_addr      = 16'h4014;
        cpu_data_in   = 8'h05;
        oam_addr_base = 8'h77;
      end
      if (k == 1) x_k1_busy = dma_busy;
      if (cpu_halt !== dma_busy) x_halt_ne++;
      if (prev_last) begin
        x_halt_after = cpu_halt;
        prev_last = 1'b0;
      end
      if (dma_busy) x_busy++;
      if (dma_rd) begin
        if (x_first_rd < 0) x_first_rd = k;
        if ((cyc % 2) != 0) x_par_bad++;
        if (dma_addr[15:8] !== exp_page) x_page_bad++;
      end
      if (oam_WE) begin
        tb_oam[oam_addr_out] = oam_data_out;
        x_wrs++;
        if (x_wrs == 1) x_first_addr = oam_addr_out;
        if (x_wrs == 9) x_ninth_addr = oam_addr_out;
        if (x_wrs == 256) prev_last = 1'b1;
      end
      if (!dma_busy || x_wrs == stop_wr) begin
        x_to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (cpu_halt !== 1'b0) begin bad++; $display("FAIL rst_cpu_halt: got %b want 0", cpu_halt); end
    total++; if (dma_busy !== 1'b0) begin bad++; $display("FAIL rst_dma_busy: got %b want 0", dma_busy); end
    total++; if (dma_rd !== 1'b0) begin bad++; $display("FAIL rst_dma_rd: got %b want 0", dma_rd); end
    total++; if (dma_addr !== 16'h0000) begin bad++; $display("FAIL rst_dma_addr: got %h want 0000", dma_addr); end
    total++; if (oam_WE !== 1'b0) begin bad++; $display("FAIL rst_oam_we: got %b want 0", oam_WE); end
    total++; if ({oam_addr_out, oam_data_out} !== 16'h0000) begin bad++; $display("FAIL rst_oam_bus: got %h want 0000", {oam_addr_out, oam_data_out}); end
    reset = 1'b0;
    step(); step();
    total++; if (dma_busy !== 1'b0) begin bad++; $display("FAIL idle_no_trigger: busy=%b want 0", dma_busy); end
  endtask

  task automatic test_basic();
    trigger(8'h02, 8'h00, 1);
    run_xfer(-1, -1, 8'h02);
    total++; if (x_to !== 1'b0) begin bad++; $display("FAIL basic_timeout: transfer did not end"); end
    total++; if (x_busy !== 513) begin bad++; $display("FAIL basic_busy: got %0d want 513", x_busy); end
    total++; if (x_wrs !== 256) begin bad++; $display("FAIL basic_writes: got %0d want 256", x_wrs); end
    total++; if (x_first_rd !== 2) begin bad++; $display("FAIL basic_first_rd: cycle %0d want 2", x_first_rd); end
    total++; if (x_par_bad !== 0) begin bad++; $display("FAIL basic_rd_parity: %0d reads on parity 1, want 0", x_par_bad); end
    total++; if (x_halt_ne !== 0) begin bad++; $display("FAIL basic_halt_eq_busy: %0d differing cycles, want 0", x_halt_ne); end
    total++; if (x_halt_after !== 1'b0) begin bad++; $display("FAIL basic_halt_release: cpu_halt=%b after last write, want 0", x_halt_after); end
    total++; if (oam_errs(8'h02, 8'h00) !== 0) begin bad++; $display("FAIL basic_oam_data: %0d wrong bytes, want 0", oam_errs(8'h02, 8'h00)); end
  endtask

  task automatic test_align();
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'($urandom);
    trigger(8'h02, 8'h00, 0);
    run_xfer(-1, -1, 8'h02);
    total++; if (x_to !== 1'b0) begin bad++; $display("FAIL align_timeout: transfer did not end"); end
    total++; if (x_busy !== 514) begin bad++; $display("FAIL align_busy: got %0d want 514", x_busy); end
    total++; if (x_first_rd !== 3) begin bad++; $display("FAIL align_first_rd: cycle %0d want 3", x_first_rd); end
    total++; if (x_par_bad !== 0) begin bad++; $display("FAIL align_rd_parity: %0d reads on parity 1, want 0", x_par_bad); end
    total++; if (oam_errs(8'h02, 8'h00) !== 0) begin bad++; $display("FAIL align_oam_data: %0d wrong bytes, want 0", oam_errs(8'h02, 8'h00)); end
  endtask

  task automatic test_wrap();
    int hp;
    hp = int'($urandom_range(1, 0));
    trigger(8'hFF, 8'hF8, hp);
    run_xfer(-1, -1, 8'hFF);
    total++; if (x_busy !== ((x_hp == 1) ? 513 : 514)) begin bad++; $display("FAIL wrap_busy: got %0d want %0d", x_busy, (x_hp == 1) ? 513 : 514); end
    total++; if (x_first_addr !== 8'hF8) begin bad++; $display("FAIL wrap_first_addr: got %h want f8", x_first_addr); end
    total++; if (x_ninth_addr !== 8'h00) begin bad++; $display("FAIL wrap_byte8_addr: got %h want 00", x_ninth_addr); end
    total++; if (x_page_bad !== 0) begin bad++; $display("FAIL wrap_page_ff: %0d reads outside page ff, want 0", x_page_bad); end
    total++; if (oam_errs(8'hFF, 8'hF8) !== 0) begin bad++; $display("FAIL wrap_oam_data: %0d wrong bytes, want 0", oam_errs(8'hFF, 8'hF8)); end
  endtask

  task automatic test_ignore();
    logic [7:0] base;
    base = 8'($urandom);
    trigger(8'h02, base, int'($urandom_range(1, 0)));
    run_xfer(int'($urandom_range(300, 20)), -1, 8'h02);
    total++; if (x_page_bad !== 0) begin bad++; $display("FAIL ignore_page: %0d reads outside page 02, want 0", x_page_bad); end
    total++; if (x_busy !== ((x_hp == 1) ? 513 : 514)) begin bad++; $display("FAIL ignore_busy: got %0d want %0d", x_busy, (x_hp == 1) ? 513 : 514); end
    total++; if (oam_errs(8'h02, base) !== 0) begin bad++; $display("FAIL ignore_oam_data: %0d wrong bytes, want 0", oam_errs(8'h02, base)); end
    step();
    total++; if (dma_busy !== 1'b0) begin bad++; $display("FAIL ignore_no_restart: busy=%b want 0", dma_busy); end
  endtask

  task automatic test_reset_mid();
    int late_we;
    int late_busy;
    trigger(8'($urandom), 8'($urandom), int'($urandom_range(1, 0)));
    run_xfer(-1, 100, cpu_data_in);
    total++; if (x_wrs !== 100) begin bad++; $display("FAIL midrst_reach100: got %0d writes want 100", x_wrs); end
    #1;
    reset = 1'b1;
    #1;
    total++; if ({cpu_halt, dma_busy, dma_rd, oam_WE} !== 4'b0000) begin bad++; $display("FAIL midrst_strobes: got %b want 0000", {cpu_halt, dma_busy, dma_rd, oam_WE}); end
    total++; if (dma_addr !== 16'h0000) begin bad++; $display("FAIL midrst_dma_addr: got %h want 0000", dma_addr); end
    total++; if ({oam_addr_out, oam_data_out} !== 16'h0000) begin bad++; $display("FAIL midrst_oam_bus: got %h want 0000", {oam_addr_out, oam_data_out}); end
    step(); step();
    reset = 1'b0;
    late_we = 0;
    late_busy = 0;
    for (int k = 0; k < 600; k++) begin
      step();
      if (oam_WE) late_we++;
      if (dma_busy) late_busy++;
    end
    total++; if (late_we !== 0) begin bad++; $display("FAIL midrst_no_resume_we: got %0d writes want 0", late_we); end
    total++; if (late_busy !== 0) begin bad++; $display("FAIL midrst_no_resume_busy: got %0d busy cycles want 0", late_busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa, ba, pb, bb;
    pa = 8'($urandom); ba = 8'($urandom);
    pb = 8'($urandom); bb = 8'($urandom);
    trigger(pa, ba, int'($urandom_range(1, 0)));
    run_xfer(-1, -1, pa);
    total++; if (x_busy !== ((x_hp == 1) ? 513 : 514)) begin bad++; $display("FAIL b2b_first_busy: got %0d want %0d", x_busy, (x_hp == 1) ? 513 : 514); end
    total++; if (oam_errs(pa, ba) !== 0) begin bad++; $display("FAIL b2b_first_data: %0d wrong bytes, want 0", oam_errs(pa, ba)); end
    trigger(pb, bb, -1);
    run_xfer(-1, -1, pb);
    total++; if (x_k1_busy !== 1'b1) begin bad++; $display("FAIL b2b_no_lost_cycle: busy=%b one cycle after trigger, want 1", x_k1_busy); end
    total++; if (x_busy !== ((x_hp == 1) ? 513 : 514)) begin bad++; $display("FAIL b2b_second_busy: got %0d want %0d", x_busy, (x_hp == 1) ? 513 : 514); end
    total++; if (x_par_bad !== 0) begin bad++; $display("FAIL b2b_rd_parity: %0d reads on parity 1, want 0", x_par_bad); end
    total++; if (oam_errs(pb, bb) !== 0) begin bad++; $display("FAIL b2b_second_data: %0d wrong bytes, want 0", oam_errs(pb, bb)); end
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = 16'h0000;
    cpu_data_in = 8'h00;
    cpu_WE = 1'b0;
    oam_addr_base = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_align();
    test_wrap();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
